dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block has one clock, and reset is synchronous and active-high.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 SHALL have port en  input  1  shift enable; 0 = all stages hold.
REQ-007 SHALL have port d  input  WIDTH  data into stage 0.
REQ-008 SHALL have port d_valid  input  1  qualifies d.
REQ-009 SHALL have port flush  input  1  invalidates all stages.
REQ-010 SHALL have port q  output  WIDTH  last-stage data (stage DEPTH-1).
REQ-011 SHALL have port q_valid  output  1  last-stage valid.
REQ-012 SHALL have port fill_cnt  output  $clog2(DEPTH+1)  count of valid stages, range 0..DEPTH.
REQ-013 SHALL have ports tap_sel (input, $clog2(DEPTH) bits, min 1) and tap_q (output, WIDTH bits), present only per REQ-027.

Function
REQ-014 SHALL, on rising clk with en=1 and flush=0: stage0 <= {d, d_valid}; stage i <= stage i-1 for i=1..DEPTH-1.
REQ-015 SHALL, with en=0 and flush=0, hold all data and valid bits unchanged; d and d_valid are ignored.
REQ-016 SHALL give latency of exactly DEPTH enabled clock edges from d to q; disabled cycles add no bubbles and drop no data.
REQ-017 SHALL, on flush=1, clear every valid bit (including the incoming d_valid) at the next edge regardless of en; data registers hold.
REQ-018 SHALL drive q and q_valid directly from stage DEPTH-1 registers (no combinational path from inputs).
REQ-019 SHALL update fill_cnt registered: with en=1, fill_cnt + d_valid - (stage DEPTH-1 valid); with en=0, unchanged; with flush, 0.
REQ-020 SHALL keep fill_cnt equal to the popcount of stage valid bits at every cycle; it never exceeds DEPTH or goes below 0.
REQ-021 SHALL, with DEPTH=1, act as a single enabled DFF with valid.
REQ-022 SHALL give priority: reset > flush > en > hold.

Reset
REQ-023 SHALL, on reset=1 at a rising clk, set all data stages to RESET_VAL, all valid bits to 0, and fill_cnt to 0; q=RESET_VAL, q_valid=0.
REQ-024 SHALL let reset asserted mid-stream discard all in-flight data; the first enabled edge after release loads stage 0 only.
REQ-025 SHALL leave outputs undefined before the first reset edge; no asynchronous reset path exists.

Configuration
REQ-026 SHALL use the macro DFF_PIPE_TAP_EN.
REQ-027 SHALL, with DFF_PIPE_TAP_EN defined, expose tap_sel/tap_q, where tap_q = data of stage tap_sel (combinational mux of registers), and tap_sel >= DEPTH selects stage DEPTH-1; without the macro, the ports and mux are absent and behaviour is otherwise identical.

Structure
REQ-028 SHALL place default WIDTH/DEPTH/RESET_VAL constants and a stage struct typedef {data, valid} in package dff_pipe_pkg.
REQ-029 SHALL instantiate DEPTH copies of sub-module dff_en_stage (one WIDTH-bit register plus valid, with sync reset, en and flush) via a generate loop.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-030 SHALL check: reset=1 for 1 edge -> q=0x00, q_valid=0, fill_cnt=0.
REQ-031 SHALL check: en=1, d_valid=1, d=0x11,0x22,0x33,0x44,0x55 on consecutive edges -> q=0x11 valid after edge 4, 0x22 after edge 5; fill_cnt 1,2,3,4,4.
REQ-032 SHALL check: pipe full, en=0 for 3 cycles while d changes -> q, q_valid, fill_cnt unchanged; the next en=1 edge resumes the sequence with no loss.
REQ-033 SHALL check: pipe full, flush=1 with en=1, d_valid=1 -> next cycle q_valid=0, fill_cnt=0, q data unchanged.
REQ-034 SHALL check: alternate d_valid 1/0 with d=0xA0,0xA1,... -> q_valid toggles after 4 edges; fill_cnt steady at 2.
REQ-035 SHALL check, with DFF_PIPE_TAP_EN: after loading 0x11..0x44, tap_sel=0..3 -> 0x44,0x33,0x22,0x11; tap_sel=3 -> 0x11.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared constants, stage record and tap helper for dff_pipe.
// Optional tap port is enabled by defining DFF_PIPE_TAP_EN.
package dff_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VAL = '0;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic                     valid;
    } stage_t;

    // Out-of-range tap selects fall back to the last stage.
    function automatic int tap_index(input int sel, input int depth);
        return (sel >= depth) ? depth - 1 : sel;
    endfunction

endpackage

// File: rtl/dff_en_stage.sv
// One pipeline register with valid bit, enable and flush.
// Flush clears valid only; the data register holds its value.
module dff_en_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = d;
            valid_d = d_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Enabled, flushable DEPTH-stage data pipe with valid and fill count.
// Define DFF_PIPE_TAP_EN to add the tap_sel/tap_q stage read port.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    input  logic                         flush,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
`ifdef DFF_PIPE_TAP_EN
    ,
    input  logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0] tap_sel,
    output logic [WIDTH-1:0]                           tap_q
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             stage_valid[DEPTH];
    logic [WIDTH-1:0] in_data    [DEPTH];
    logic             in_valid   [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign in_data[i]  = d;
            assign in_valid[i] = d_valid;
        end else begin : g_link
            assign in_data[i]  = stage_data[i-1];
            assign in_valid[i] = stage_valid[i-1];
        end

        dff_en_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .flush   (flush),
            .d       (in_data[i]),
            .d_valid (in_valid[i]),
            .q       (stage_data[i]),
            .q_valid (stage_valid[i])
        );
    end

    // Count tracks valid entries: one enters at stage 0, one leaves the tail.
    logic [CW-1:0] fill_d, fill_q;

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (en) begin
            fill_d = fill_q + CW'(d_valid) - CW'(stage_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign q        = stage_data[DEPTH-1];
    assign q_valid  = stage_valid[DEPTH-1];
    assign fill_cnt = fill_q;

`ifdef DFF_PIPE_TAP_EN
    always_comb begin
        tap_q = stage_data[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_index(int'(tap_sel), DEPTH) == i) begin
                tap_q = stage_data[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Vector table plus randomized run against a queue-based pipe model.
// Tap checks are compiled in when DFF_PIPE_TAP_EN is defined.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  d = '0;
    logic          d_valid = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  q;
    logic          q_valid;
    logic [CW-1:0] fill_cnt;
`ifdef DFF_PIPE_TAP_EN
    logic [1:0]    tap_sel = '0;
    logic [W-1:0]  tap_q;
`endif

    int n_run  = 0;
    int n_fail = 0;

    dff_pipe #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .d        (d),
        .d_valid  (d_valid),
        .flush    (flush),
        .q        (q),
        .q_valid  (q_valid),
        .fill_cnt (fill_cnt)
`ifdef DFF_PIPE_TAP_EN
        ,
        .tap_sel  (tap_sel),
        .tap_q    (tap_q)
`endif
    );

    always #5 clk = ~clk;

    // Model: queue index 0 is the newest stage, index D-1 feeds q.
    stage_t pipe[$];

    function automatic int model_fill();
        int n = 0;
        foreach (pipe[i]) n += int'(pipe[i].valid);
        return n;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic f,
                              input logic [W-1:0] dd, input logic dv);
        stage_t s;
        if (r) begin
            pipe.delete();
            for (int i = 0; i < D; i++) pipe.push_back('{data: 8'h00, valid: 1'b0});
        end else if (f) begin
            foreach (pipe[i]) pipe[i].valid = 1'b0;
        end else if (e) begin
            s.data  = dd;
            s.valid = dv;
            pipe.push_front(s);
            void'(pipe.pop_back());
        end
    endtask

    task automatic step(input logic r, input logic e, input logic f,
                        input logic [W-1:0] dd, input logic dv);
        reset   = r;
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
        @(posedge clk);
        #1;
        model_edge(r, e, f, dd, dv);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         r, e, f, dv;
        logic [W-1:0] d;
        logic [W-1:0] eq;
        logic         eqv;
        int           ef;
        string        name;
    } vec_t;

    vec_t vt[$];

    task automatic add(input string nm, input logic r, input logic e,
                       input logic f, input logic [W-1:0] dd, input logic dv,
                       input logic [W-1:0] eq, input logic eqv, input int ef);
        vec_t v;
        v.name = nm; v.r = r; v.e = e; v.f = f; v.d = dd; v.dv = dv;
        v.eq = eq; v.eqv = eqv; v.ef = ef;
        vt.push_back(v);
    endtask

    initial begin
        // name          r  e  f  d      dv  q      qv  fill
        add("reset",     1, 0, 0, 8'hFF, 1, 8'h00, 0, 0);
        add("load1",     0, 1, 0, 8'h11, 1, 8'h00, 0, 1);
        add("load2",     0, 1, 0, 8'h22, 1, 8'h00, 0, 2);
        add("load3",     0, 1, 0, 8'h33, 1, 8'h00, 0, 3);
        add("load4",     0, 1, 0, 8'h44, 1, 8'h11, 1, 4);
        add("load5",     0, 1, 0, 8'h55, 1, 8'h22, 1, 4);
        add("hold1",     0, 0, 0, 8'hE1, 1, 8'h22, 1, 4);
        add("hold2",     0, 0, 0, 8'hE2, 0, 8'h22, 1, 4);
        add("hold3",     0, 0, 0, 8'hE3, 1, 8'h22, 1, 4);
        add("resume",    0, 1, 0, 8'h66, 1, 8'h33, 1, 4);
        add("flush",     0, 1, 1, 8'h77, 1, 8'h33, 0, 0);
        add("alt_a0",    0, 1, 0, 8'hA0, 1, 8'h44, 0, 1);
        add("alt_a1",    0, 1, 0, 8'hA1, 0, 8'h55, 0, 1);
        add("alt_a2",    0, 1, 0, 8'hA2, 1, 8'h66, 0, 2);
        add("alt_a3",    0, 1, 0, 8'hA3, 0, 8'hA0, 1, 2);
        add("alt_a4",    0, 1, 0, 8'hA4, 1, 8'hA1, 0, 2);
        add("alt_a5",    0, 1, 0, 8'hA5, 0, 8'hA2, 1, 2);
        add("alt_a6",    0, 1, 0, 8'hA6, 1, 8'hA3, 0, 2);
        add("alt_a7",    0, 1, 0, 8'hA7, 0, 8'hA4, 1, 2);
        add("flush_en0", 0, 0, 1, 8'h00, 1, 8'hA4, 0, 0);
        add("rst_flush", 1, 1, 1, 8'h99, 1, 8'h00, 0, 0);
        add("mid_ld1",   0, 1, 0, 8'hC1, 1, 8'h00, 0, 1);
        add("mid_ld2",   0, 1, 0, 8'hC2, 1, 8'h00, 0, 2);
        add("mid_rst",   1, 1, 0, 8'hC3, 1, 8'h00, 0, 0);
        add("post_rst1", 0, 1, 0, 8'h5A, 1, 8'h00, 0, 1);
        add("post_rst2", 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
        add("post_rst3", 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
        add("post_rst4", 0, 1, 0, 8'h00, 0, 8'h5A, 1, 1);
        add("drain",     0, 1, 0, 8'h00, 0, 8'h00, 0, 0);

        foreach (vt[k]) begin
            step(vt[k].r, vt[k].e, vt[k].f, vt[k].d, vt[k].dv);
            chk({vt[k].name, ".q"},    int'(q),        int'(vt[k].eq));
            chk({vt[k].name, ".qv"},   int'(q_valid),  int'(vt[k].eqv));
            chk({vt[k].name, ".fill"}, int'(fill_cnt), vt[k].ef);
        end

`ifdef DFF_PIPE_TAP_EN
        begin
            logic [W-1:0] exp_tap [4];
            exp_tap[0] = 8'h44; exp_tap[1] = 8'h33;
            exp_tap[2] = 8'h22; exp_tap[3] = 8'h11;
            step(1, 0, 0, 8'h00, 0);
            step(0, 1, 0, 8'h11, 1);
            step(0, 1, 0, 8'h22, 1);
            step(0, 1, 0, 8'h33, 1);
            step(0, 1, 0, 8'h44, 1);
            en = 1'b0;
            for (int s = 0; s < 4; s++) begin
                tap_sel = 2'(s);
                #1;
                chk($sformatf("tap%0d", s), int'(tap_q), int'(exp_tap[s]));
            end
        end
`endif

        // Randomized run against the queue model.
        step(1, 0, 0, 8'h00, 0);
        for (int c = 0; c < 2000; c++) begin
            logic r, e, f, dv;
            logic [W-1:0] dd;
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 99) < 4);
            e  = ($urandom_range(0, 99) < 70);
            dv = ($urandom_range(0, 99) < 60);
            dd = W'($urandom);
            step(r, e, f, dd, dv);
            chk("rand.q",    int'(q),        int'(pipe[D-1].data));
            chk("rand.qv",   int'(q_valid),  int'(pipe[D-1].valid));
            chk("rand.fill", int'(fill_cnt), model_fill());
`ifdef DFF_PIPE_TAP_EN
            tap_sel = 2'($urandom_range(0, 3));
            #1;
            chk("rand.tap", int'(tap_q),
                int'(pipe[tap_index(int'(tap_sel), D)].data));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
